uart_message_sequencer: RTL
===========================

// Module: uart_message_sequencer
// PURPOSE
//  Parametrised UART message printer: a trigger byte on the RX stream selects one of
//  NUM_MSG NUL-terminated messages in an external synchronous ROM, which are streamed
//  byte-by-byte to the UART TX. Supports abort, busy/done/aborted status, and a length cap.
//  Sits between uart_rx/uart_tx and a message ROM; it is the generalised successor of the
//  single-message printer.
// PARAMETERS
//  NUM_MSG      4     number of messages; SEL_W = max(1, $clog2(NUM_MSG))
//  MSG_LEN_MAX  32    max bytes per message (power of 2, >=2); IDX_W = $clog2(MSG_LEN_MAX)
//  TRIG_BASE    "0"   trigger byte for message 0; message k is triggered by TRIG_BASE+k
//  ABORT_CHAR   "!"   RX byte that aborts an active message
// PORTS
//  clk          in   1              clock
//  rst          in   1              synchronous, active-high reset
//  rx_data      in   8              received byte
//  new_rx_data  in   1              1-cycle strobe: rx_data valid
//  tx_data      out  8              byte to transmit (registered)
//  new_tx_data  out  1              1-cycle strobe to uart_tx (registered)
//  tx_busy      in   1              uart_tx busy; asserts the cycle after new_tx_data
//  rom_addr     out  SEL_W+IDX_W    {msg_sel, char_idx} (registered)
//  rom_data     in   8              ROM byte, valid 1 cycle after rom_addr changes
//  busy         out  1              high while not IDLE
//  done         out  1              1-cycle pulse: message finished normally
//  aborted      out  1              1-cycle pulse: message terminated by ABORT_CHAR
//  cur_msg      out  SEL_W          index of the active or last message
// BEHAVIOUR
//  Reset: state=IDLE; tx_data=0, new_tx_data=0, rom_addr=0, busy=0, done=0, aborted=0, cur_msg=0.
//   Reset mid-message returns to IDLE on the next edge with no further TX strobe.
//  States: IDLE, FETCH, WAIT_TX.
//  IDLE: on new_rx_data with TRIG_BASE <= rx_data < TRIG_BASE+NUM_MSG:
//   cur_msg <= rx_data-TRIG_BASE, rom_addr <= {sel,0}, go FETCH. Other bytes, incl. ABORT_CHAR, ignored.
//  FETCH: exactly 1 cycle (covers ROM latency and the tx_busy rise delay) -> WAIT_TX.
//  WAIT_TX: rom_data is valid.
//   - If rom_data==8'h00: done<=1, go IDLE; nothing is sent.
//   - Else if !tx_busy: tx_data<=rom_data, new_tx_data<=1 for 1 cycle.
//     If char_idx==MSG_LEN_MAX-1: done<=1, go IDLE (length cap, no terminator needed).
//     Otherwise: char_idx+1, go FETCH.
//   - Else hold; new_tx_data=0.
//  Minimum cadence: 1 byte per 2 cycles when tx_busy stays low.
//  Abort: new_rx_data with rx_data==ABORT_CHAR in FETCH or WAIT_TX -> aborted<=1, go IDLE;
//   abort takes priority over a same-cycle send (no strobe that cycle). A byte already
//   strobed stays in flight in uart_tx.
//  Triggers while busy: ignored (no queueing). done and aborted are never high together.
//  busy is 1 from the cycle after the trigger until the cycle that done/aborted is high, inclusive.
//  char_idx never wraps: max value MSG_LEN_MAX-1, and it is reset to 0 on every trigger.
//  Out-of-range trigger (>= TRIG_BASE+NUM_MSG): ignored, no state change.
// TESTING
//  1 Trigger "0", ROM msg0="Hi\0", tx_busy low -> 2 strobes 'H','i' 2 cycles apart, then done pulse;
//    rom_addr sequence 0,1,2.
//  2 Trigger "2" (NUM_MSG=4) -> cur_msg=2, rom_addr[MSB:IDX_W]=2; out-of-range trigger "7" -> no activity.
//  3 tx_busy held high 10 cycles after the first strobe -> no strobe until tx_busy falls;
//    next byte strobes the cycle after it falls.
//  4 Msg with no NUL, MSG_LEN_MAX=32 -> exactly 32 strobes, done together with the 32nd;
//    char_idx does not wrap.
//  5 "!" received mid-message -> aborted pulse, no done, no further strobes; a re-trigger then
//    restarts at char_idx=0.
//  6 rst asserted in WAIT_TX -> all outputs 0 the next cycle; "1" during busy -> ignored,
//    and msg1 does not start afterward.

Source files
------------

// File: rtl/uart_message_sequencer.sv
// uart_message_sequencer
// A trigger byte on the RX stream selects one of NUM_MSG NUL-terminated messages
// held in an external synchronous ROM. The message is streamed byte by byte to the
// UART transmitter until a NUL byte is read, the length cap is reached, or an abort
// byte arrives.
module uart_message_sequencer #(
    parameter int         NUM_MSG     = 4,
    parameter int         MSG_LEN_MAX = 32,
    parameter logic [7:0] TRIG_BASE   = 8'h30,
    parameter logic [7:0] ABORT_CHAR  = 8'h21,
    localparam int        SEL_W       = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1,
    localparam int        IDX_W       = $clog2(MSG_LEN_MAX)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     new_rx_data,
    output logic [7:0]               tx_data,
    output logic                     new_tx_data,
    input  logic                     tx_busy,
    output logic [SEL_W+IDX_W-1:0]   rom_addr,
    input  logic [7:0]               rom_data,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic [SEL_W-1:0]         cur_msg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        WAIT_TX = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               new_tx_q, new_tx_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    // Trigger range check done in 9 bits so TRIG_BASE+NUM_MSG cannot overflow.
    logic [8:0]         rx_ext;
    logic [8:0]         trig_lo;
    logic [8:0]         trig_hi;
    logic               is_trig;
    logic               is_abort;
    logic [SEL_W-1:0]   trig_sel;
    logic               idx_last;

    assign rx_ext   = {1'b0, rx_data};
    assign trig_lo  = {1'b0, TRIG_BASE};
    assign trig_hi  = trig_lo + 9'(NUM_MSG);
    assign is_trig  = new_rx_data && (rx_ext >= trig_lo) && (rx_ext < trig_hi);
    assign is_abort = new_rx_data && (rx_data == ABORT_CHAR);
    assign trig_sel = SEL_W'(rx_data - TRIG_BASE);
    assign idx_last = (idx_q == IDX_W'(MSG_LEN_MAX - 1));

    // Next-state and registered-output decisions for the sequencer FSM.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        new_tx_d  = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Abort bytes and out-of-range bytes fall through untouched.
                if (is_trig) begin
                    sel_d   = trig_sel;
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // One dead cycle: ROM read latency and lets tx_busy rise after a strobe.
                if (is_abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // Abort wins over a same-cycle send; a NUL ends the message silently.
                if (is_abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (rom_data == 8'h00) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (!tx_busy) begin
                    tx_data_d = rom_data;
                    new_tx_d  = 1'b1;
                    if (idx_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            idx_q     <= '0;
            tx_data_q <= 8'h00;
            new_tx_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
            new_tx_q  <= new_tx_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_q;
    assign rom_addr    = {sel_q, idx_q};
    assign cur_msg     = sel_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    // Stays high through the done/aborted pulse cycle even though the FSM is already idle.
    assign busy        = (state_q != IDLE) || done_q || aborted_q;

endmodule
